// File: rtl/bsg_manycore_host_mem_responder.sv
// rtl/bsg_manycore_host_mem_responder.sv - manycore request responder over a byte-maskable scratchpad
// Loads return a data packet after a registered RAM read; stores and illegal ops are consumed silently.
module bsg_manycore_host_mem_responder #(
  parameter int fifo_width_p    = 128,
  parameter int mem_els_p       = 1024,
  parameter int counter_width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_v_i,
  input  logic [fifo_width_p-1:0]    req_data_i,
  output logic                       req_ready_o,
  output logic                       rsp_v_o,
  output logic [fifo_width_p-1:0]    rsp_data_o,
  input  logic                       rsp_ready_i,
  output logic [counter_width_p-1:0] load_count_o,
  output logic [counter_width_p-1:0] store_count_o,
  output logic [counter_width_p-1:0] err_count_o,
  output logic                       busy_o
);

  localparam int addr_w_lp = $clog2(mem_els_p);
  localparam logic [31:0] mem_els_lp = 32'(mem_els_p);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                     state_q, state_d;
  logic                       rsp_v_q, rsp_v_d;
  logic [31:0]                load_id_q, load_id_d;
  logic [15:0]                src_q, src_d;
  logic                       oor_q, oor_d;
  logic [counter_width_p-1:0] load_cnt_q, load_cnt_d;
  logic [counter_width_p-1:0] store_cnt_q, store_cnt_d;
  logic [counter_width_p-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]                rd_data_q;
  logic [31:0]                mem [mem_els_p];

  logic [31:0]          req_addr;
  logic [7:0]           req_op;
  logic [3:0]           req_mask;
  logic [31:0]          req_wdata;
  logic [addr_w_lp-1:0] mem_idx;
  logic                 accept, is_load, is_store, oor, mem_we, mem_re;
  logic                 unused_bits;

  assign req_addr  = req_data_i[111:80];
  assign req_op    = req_data_i[79:72];
  assign req_mask  = req_data_i[67:64];
  assign req_wdata = req_data_i[63:32];
  assign mem_idx   = req_addr[addr_w_lp-1:0];
  assign unused_bits = ^{req_data_i[127:112], req_data_i[71:68], req_data_i[15:0]};

  assign req_ready_o = (state_q == IDLE) & ~reset_i;
  assign accept      = req_v_i & req_ready_o;
  assign is_load     = (req_op == 8'h00);
  assign is_store    = (req_op == 8'h01);
  assign oor         = (req_addr >= mem_els_lp);
  assign mem_we      = accept & is_store & ~oor;
  assign mem_re      = accept & is_load & ~oor;

  function automatic logic [counter_width_p-1:0] sat_inc(input logic [counter_width_p-1:0] v);
    return (v == '1) ? v : v + counter_width_p'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    rsp_v_d     = rsp_v_q;
    load_id_d   = load_id_q;
    src_d       = src_q;
    oor_d       = oor_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: if (accept && is_load) begin
        state_d   = RESP;
        rsp_v_d   = 1'b1;
        load_id_d = req_wdata;
        src_d     = req_data_i[31:16];
        oor_d     = oor;
      end
      RESP: if (rsp_ready_i) begin
        state_d = IDLE;
        rsp_v_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Out-of-range loads still answer but count only as errors.
    if (accept) begin
      if (is_load && !oor)  load_cnt_d  = sat_inc(load_cnt_q);
      if (is_store && !oor) store_cnt_d = sat_inc(store_cnt_q);
      if (oor || !(is_load || is_store)) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rsp_v_q     <= 1'b0;
      load_id_q   <= '0;
      src_q       <= '0;
      oor_q       <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_v_q     <= rsp_v_d;
      load_id_q   <= load_id_d;
      src_q       <= src_d;
      oor_q       <= oor_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Scratchpad: no reset, read register updates only on an accepted in-range load.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && req_mask[i]) mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
    end
    if (mem_re) rd_data_q <= mem[mem_idx];
  end

  assign rsp_v_o       = rsp_v_q;
  assign rsp_data_o    = rsp_v_q ? {40'h0, 8'h01, (oor_q ? 32'h0 : rd_data_q), load_id_q, src_q} : '0;
  assign load_count_o  = load_cnt_q;
  assign store_count_o = store_cnt_q;
  assign err_count_o   = err_cnt_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_bsg_manycore_host_mem_responder.sv
// tb/tb_bsg_manycore_host_mem_responder.sv - directed vector bench for bsg_manycore_host_mem_responder
// Table of requests with cumulative counter expectations, plus backpressure, streaming and reset sequences.
module tb_bsg_manycore_host_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_v;
  logic [127:0] req_data;
  logic         req_ready;
  logic         rsp_v;
  logic [127:0] rsp_data;
  logic         rsp_ready;
  logic [31:0]  load_count, store_count, err_count;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bsg_manycore_host_mem_responder #(
    .fifo_width_p(128), .mem_els_p(1024), .counter_width_p(32)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_data_i(req_data), .req_ready_o(req_ready),
    .rsp_v_o(rsp_v), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
    .load_count_o(load_count), .store_count_o(store_count), .err_count_o(err_count),
    .busy_o(busy)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        rsp;
    logic [31:0] rdata;
    int          nl;
    int          ns;
    int          ne;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_req(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [3:0] mask, input logic [31:0] data);
    return {16'hBEEF, addr, op, 4'hA, mask, data, 8'd3, 8'd2, 8'h11, 8'h22};
  endfunction

  function automatic logic [127:0] mk_rsp(input logic [31:0] rdata, input logic [31:0] id);
    return {40'h0, 8'h01, rdata, id, 8'd3, 8'd2};
  endfunction

  task automatic check_counts(input string tag, input int nl, input int ns, input int ne);
    check({tag, " load_count"},  128'(load_count),  128'(nl));
    check({tag, " store_count"}, 128'(store_count), 128'(ns));
    check({tag, " err_count"},   128'(err_count),   128'(ne));
  endtask

  initial begin
    vecs[0]  = '{8'h00+8'h01, 32'd5,    4'hF, 32'hA5A5_1234, 1'b0, 32'h0,          0, 1, 0};
    vecs[1]  = '{8'h00,       32'd5,    4'h0, 32'd7,         1'b1, 32'hA5A5_1234,  1, 1, 0};
    vecs[2]  = '{8'h01,       32'd0,    4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,          1, 2, 0};
    vecs[3]  = '{8'h01,       32'd0,    4'h5, 32'h0,         1'b0, 32'h0,          1, 3, 0};
    vecs[4]  = '{8'h00,       32'd0,    4'h0, 32'h11,        1'b1, 32'hFF00_FF00,  2, 3, 0};
    vecs[5]  = '{8'h01,       32'd1024, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,          2, 3, 1};
    vecs[6]  = '{8'h00,       32'd2000, 4'h0, 32'd9,         1'b1, 32'h0,          2, 3, 2};
    vecs[7]  = '{8'h01,       32'd1023, 4'hF, 32'hCAFE_BABE, 1'b0, 32'h0,          2, 4, 2};
    vecs[8]  = '{8'h01,       32'd1023, 4'h8, 32'h0,         1'b0, 32'h0,          2, 5, 2};
    vecs[9]  = '{8'h00,       32'd1023, 4'h0, 32'h23,        1'b1, 32'h00FE_BABE,  3, 5, 2};
    vecs[10] = '{8'h02,       32'd5,    4'hF, 32'h0,         1'b0, 32'h0,          3, 5, 3};
    vecs[11] = '{8'h01,       32'd5,    4'h0, 32'h0,         1'b0, 32'h0,          3, 6, 3};
    vecs[12] = '{8'h00,       32'd5,    4'h0, 32'h55,        1'b1, 32'hA5A5_1234,  4, 6, 3};
    vecs[13] = '{8'hFF,       32'd0,    4'hF, 32'h1,         1'b0, 32'h0,          4, 6, 4};

    reset = 1'b1; req_v = 1'b0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset req_ready", 128'(req_ready), 128'(0));
    check("reset rsp_v",     128'(rsp_v),     128'(0));
    check("reset rsp_data",  rsp_data,        128'(0));
    check("reset busy",      128'(busy),      128'(0));
    check_counts("reset", 0, 0, 0);
    reset = 1'b0;
    #1 check("ready after reset", 128'(req_ready), 128'(1));

    // Stores flow back-to-back into the next request; loads get one handshake cycle.
    for (int i = 0; i < 14; i++) begin
      check($sformatf("v%0d ready", i), 128'(req_ready), 128'(1));
      req_v = 1'b1;
      req_data = mk_req(vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].data);
      @(negedge clk);
      check_counts($sformatf("v%0d", i), vecs[i].nl, vecs[i].ns, vecs[i].ne);
      check($sformatf("v%0d rsp_v", i), 128'(rsp_v), 128'(vecs[i].rsp));
      if (vecs[i].rsp) begin
        check($sformatf("v%0d rsp_data", i), rsp_data, mk_rsp(vecs[i].rdata, vecs[i].data));
        check($sformatf("v%0d busy", i), 128'(busy), 128'(1));
        req_v = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d rsp_v after hs", i), 128'(rsp_v), 128'(0));
      end
    end
    req_v = 1'b0;

    // Backpressure: five cycles stalled, handshake on the sixth.
    rsp_ready = 1'b0;
    req_v = 1'b1;
    req_data = mk_req(8'h00, 32'd5, 4'h0, 32'h77);
    @(negedge clk);
    req_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d rsp_v", k), 128'(rsp_v), 128'(1));
      check($sformatf("bp%0d rsp_data", k), rsp_data, mk_rsp(32'hA5A5_1234, 32'h77));
      check($sformatf("bp%0d req_ready", k), 128'(req_ready), 128'(0));
      check($sformatf("bp%0d busy", k), 128'(busy), 128'(1));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("bp6 rsp_v", 128'(rsp_v), 128'(1));
    @(negedge clk);
    check("bp after hs rsp_v", 128'(rsp_v), 128'(0));
    check("bp after hs req_ready", 128'(req_ready), 128'(1));
    check("bp after hs busy", 128'(busy), 128'(0));
    check_counts("bp", 5, 6, 4);

    // Four stores with req_v held high.
    req_v = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_data = mk_req(8'h01, 32'(100 + k), 4'hF, 32'h1000 + 32'(k));
      #1 check($sformatf("stream%0d req_ready", k), 128'(req_ready), 128'(1));
      @(negedge clk);
    end
    check("stream store_count", 128'(store_count), 128'(10));
    req_data = mk_req(8'h00, 32'd102, 4'h0, 32'h66);
    @(negedge clk);
    req_v = 1'b0;
    check("stream readback", rsp_data, mk_rsp(32'h0000_1002, 32'h66));
    @(negedge clk);

    // Reset while holding an unacknowledged response.
    rsp_ready = 1'b0;
    req_v = 1'b1;
    req_data = mk_req(8'h00, 32'd0, 4'h0, 32'h99);
    @(negedge clk);
    req_v = 1'b0;
    check("pre-reset rsp_v", 128'(rsp_v), 128'(1));
    reset = 1'b1;
    #1 check("in reset req_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    check("mid reset rsp_v", 128'(rsp_v), 128'(0));
    check("mid reset rsp_data", rsp_data, 128'(0));
    check("mid reset busy", 128'(busy), 128'(0));
    check("mid reset req_ready", 128'(req_ready), 128'(0));
    check_counts("mid reset", 0, 0, 0);
    reset = 1'b0;
    #1 check("post reset req_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    check("post reset rsp_v", 128'(rsp_v), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
